img_pass_sched: RTL
===================

IMG_PASS_SCHED -- requirements
Module: img_pass_sched

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 20'hFFFFF, maximum cycles one engine pass may take before abort.
REQ-002 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: cmd_valid  in  1  host presents a pass sequence.
REQ-005 SHALL have port: cmd_ops  in  6  three 2-bit op slots, slot0=[1:0] runs first; 0 none, 1 mirror, 2 gray, 3 sharpen.
REQ-006 SHALL have port: cmd_ready  out  1  sequence accepted when cmd_valid&&cmd_ready.
REQ-007 SHALL have port: host_req  in  1  host asks for the image memory port (load/unload).
REQ-008 SHALL have port: host_gnt  out  1  host owns the image memory port; engine does not.
REQ-009 SHALL have port: eng_start  out  1  one-cycle launch pulse to the processing engine.
REQ-010 SHALL have port: eng_op  out  2  op code for the launched pass, stable from eng_start until that pass ends.
REQ-011 SHALL have port: eng_done  in  1  engine completion pulse (mirror/gray/filter done, ORed).
REQ-012 SHALL have port: pass_idx  out  2  slot currently running.
REQ-013 SHALL have port: busy  out  1  high in every state except IDLE and HOST.
REQ-014 SHALL have port: seq_done  out  1  one-cycle pulse at sequence end.
REQ-015 SHALL have port: err  out  1  sticky timeout flag.

Function
REQ-016 SHALL implement FSM states IDLE, HOST, LAUNCH, WAIT, NEXT, DONE.
REQ-017 IDLE: cmd_ready=1; host_req -> HOST (host wins if cmd_valid in same cycle); else cmd_valid -> latch cmd_ops, slot=0, clear err -> LAUNCH.
REQ-018 HOST: host_gnt=1, cmd_ready=0; stays while host_req=1; host_req=0 -> IDLE, host_gnt falls in that cycle.
REQ-019 LAUNCH: if op[slot]==0, no pulse, -> NEXT; else eng_start=1 for exactly one cycle, eng_op=op[slot], timer cleared -> WAIT.
REQ-020 WAIT: timer increments each cycle; eng_done=1 -> NEXT; timer==TIMEOUT_CYC without eng_done -> err=1 -> DONE (remaining slots abandoned).
REQ-021 eng_done and timeout in the same cycle SHALL count as done; err stays 0.
REQ-022 NEXT: slot==2 -> DONE; else slot+1 -> LAUNCH.
REQ-023 DONE: seq_done=1 one cycle -> IDLE; eng_op returns to 0.
REQ-024 Latency: accept at edge N -> eng_start high in cycle N+1 when slot0 nonzero; each skipped slot adds 2 cycles; cmd_ops=0 gives seq_done 6 cycles after accept.
REQ-025 eng_done outside WAIT SHALL be ignored, no state change.
REQ-026 cmd_valid and host_req outside IDLE SHALL be ignored; no queuing.
REQ-027 Timer SHALL be 20 bits and saturate; it never wraps.

Reset
REQ-028 rst_n low SHALL force IDLE asynchronously, mid-pass included: eng_start, eng_op, pass_idx, host_gnt, busy, seq_done and err = 0; cmd_ready = 1 after release.
REQ-029 Reset SHALL clear the latched cmd_ops, slot and timer.

Structure
REQ-030 Shared package img_pkg SHALL hold op codes (OP_NONE/MIRROR/GRAY/SHARP), the FSM state enum and the TIMEOUT_CYC default.
REQ-031 Watchdog timer SHALL be sub-module pass_watchdog (clear, enable, saturate, hit flag).

Verification
REQ-032 cmd_ops=6'b11_10_01 with engine model done after 10 cycles -> eng_start x3, eng_op 1,2,3, pass_idx 0,1,2, one seq_done, err=0.
REQ-033 cmd_ops=6'b00_11_00 -> one eng_start with eng_op=3, pass_idx=1; slots 0 and 2 skipped.
REQ-034 cmd_valid and host_req asserted together in IDLE -> host_gnt=1, cmd_ready=0 until host_req drops, then the command is accepted.
REQ-035 TIMEOUT_CYC=16, engine never responds -> err=1 after 16 WAIT cycles, seq_done pulse, slots 1-2 never launched; next accept clears err.
REQ-036 rst_n pulled low during WAIT of slot 1 -> all outputs 0 immediately; next command restarts at slot 0.
REQ-037 eng_done pulsed in IDLE and HOST -> no state or output change.

Source files
------------

// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared op codes, FSM states and timing constants for the image pass scheduler
// Contents: op_e (engine op codes), state_e (scheduler FSM), TIMER_W, TIMEOUT_CYC_DFLT, slot_op().
package img_pkg;

    typedef enum logic [1:0] {
        OP_NONE   = 2'd0,
        OP_MIRROR = 2'd1,
        OP_GRAY   = 2'd2,
        OP_SHARP  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOST   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam int              TIMER_W          = 20;
    localparam logic [TIMER_W-1:0] TIMEOUT_CYC_DFLT = 20'hFFFFF;
    localparam logic [1:0]      LAST_SLOT        = 2'd2;

    // Pick the 2-bit op for a slot out of the packed three-slot command word.
    function automatic op_e slot_op(input logic [5:0] ops, input logic [1:0] slot);
        case (slot)
            2'd0:    return op_e'(ops[1:0]);
            2'd1:    return op_e'(ops[3:2]);
            default: return op_e'(ops[5:4]);
        endcase
    endfunction

endpackage

// File: rtl/pass_watchdog.sv
// rtl/pass_watchdog.sv - saturating per-pass cycle counter with a limit-reached flag
// Ports: clk, rst_n (async, active-low), clr_i (zero the count), en_i (count this cycle),
//        hit_o (this counted cycle brings the count to LIMIT).
module pass_watchdog
    import img_pkg::*;
#(
    parameter logic [TIMER_W-1:0] LIMIT = TIMEOUT_CYC_DFLT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;
    logic [TIMER_W-1:0] cnt_inc;

    // Saturate at all-ones so a stuck engine can never wrap the count back under LIMIT.
    assign cnt_inc = (cnt_q == {TIMER_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_inc;
        end
    end

    // The count includes the current cycle, so hit_o fires on the LIMIT-th enabled cycle.
    assign hit_o = en_i && !clr_i && (cnt_inc == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/img_pass_sched.sv
// rtl/img_pass_sched.sv - sequences up to three image engine passes and arbitrates the image memory port
// Ports: clk, rst_n (async, active-low)
//        cmd_valid/cmd_ops/cmd_ready : host pass-sequence handshake, slot0 = cmd_ops[1:0]
//        host_req/host_gnt           : host ownership of the image memory port
//        eng_start/eng_op/eng_done   : engine launch pulse, op code, completion pulse
//        pass_idx, busy, seq_done, err : status (err is sticky until the next accept)
module img_pass_sched
    import img_pkg::*;
#(
    parameter logic [TIMER_W-1:0] TIMEOUT_CYC = TIMEOUT_CYC_DFLT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [5:0] cmd_ops,
    output logic       cmd_ready,
    input  logic       host_req,
    output logic       host_gnt,
    output logic       eng_start,
    output logic [1:0] eng_op,
    input  logic       eng_done,
    output logic [1:0] pass_idx,
    output logic       busy,
    output logic       seq_done,
    output logic       err
);

    state_e     state_q;
    logic [5:0] ops_q;
    logic [1:0] slot_q;
    logic       eng_start_q;
    op_e        eng_op_q;
    logic       seq_done_q;
    logic       err_q;

    op_e        cur_op;
    logic       wd_clr;
    logic       wd_en;
    logic       wd_hit;

    assign cur_op = slot_op(ops_q, slot_q);

    // Timer restarts at every launch and only runs while a pass is outstanding.
    assign wd_clr = (state_q == ST_LAUNCH);
    assign wd_en  = (state_q == ST_WAIT);

    pass_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (wd_clr),
        .en_i  (wd_en),
        .hit_o (wd_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ops_q       <= '0;
            slot_q      <= '0;
            eng_start_q <= 1'b0;
            eng_op_q    <= OP_NONE;
            seq_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            eng_start_q <= 1'b0;
            seq_done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Host has priority so a load/unload is never starved by a queued command.
                    if (host_req) begin
                        state_q <= ST_HOST;
                    end else if (cmd_valid) begin
                        ops_q   <= cmd_ops;
                        slot_q  <= '0;
                        err_q   <= 1'b0;
                        state_q <= ST_LAUNCH;
                    end
                end
                ST_HOST: begin
                    if (!host_req) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    if (cur_op == OP_NONE) begin
                        state_q <= ST_NEXT;
                    end else begin
                        eng_start_q <= 1'b1;
                        eng_op_q    <= cur_op;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A completion arriving on the timeout cycle still counts as success.
                    if (eng_done) begin
                        state_q <= ST_NEXT;
                    end else if (wd_hit) begin
                        err_q      <= 1'b1;
                        seq_done_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_NEXT: begin
                    if (slot_q == LAST_SLOT) begin
                        seq_done_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        slot_q  <= slot_q + 2'd1;
                        state_q <= ST_LAUNCH;
                    end
                end
                ST_DONE: begin
                    eng_op_q <= OP_NONE;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign host_gnt  = (state_q == ST_HOST);
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_HOST);
    assign eng_start = eng_start_q;
    assign eng_op    = eng_op_q;
    assign pass_idx  = slot_q;
    assign seq_done  = seq_done_q;
    assign err       = err_q;

endmodule
